// File: rtl/riscvlong_sb_pkg.sv
// Shared types and constants for the long-pipeline register scoreboard.
package riscvlong_sb_pkg;

    // Result producer classes
    localparam logic [1:0] UNIT_ALU    = 2'd0;
    localparam logic [1:0] UNIT_LOAD   = 2'd1;
    localparam logic [1:0] UNIT_MULDIV = 2'd2;

    // Decode-stage operand bypass selects
    localparam logic [2:0] BYP_RF = 3'd0;
    localparam logic [2:0] BYP_X  = 3'd1;
    localparam logic [2:0] BYP_M  = 3'd2;
    localparam logic [2:0] BYP_X2 = 3'd3;
    localparam logic [2:0] BYP_X3 = 3'd4;
    localparam logic [2:0] BYP_W  = 3'd5;

    // Stage indices, youngest first
    localparam int unsigned STG_X   = 0;
    localparam int unsigned STG_M   = 1;
    localparam int unsigned STG_X2  = 2;
    localparam int unsigned STG_X3  = 3;
    localparam int unsigned STG_W   = 4;
    localparam int unsigned NUM_STG = 5;

    // Per-stage destination descriptor
    typedef struct packed {
        logic       val;
        logic [4:0] rd;
        logic [1:0] unit;
    } sb_desc_t;

    localparam int unsigned DESC_W = $bits(sb_desc_t);

    // True when a result of this producer class can be forwarded from this stage.
    // The reserved class 3 behaves like MULDIV.
    function automatic logic unit_ready(int unsigned stg, logic [1:0] unit);
        if (unit == UNIT_ALU) begin
            return 1'b1;
        end
        if (unit == UNIT_LOAD) begin
            return stg != STG_X;
        end
        return stg == STG_W;
    endfunction

    // Bypass select code for a stage index
    function automatic logic [2:0] stage_byp(int unsigned stg);
        case (stg)
            STG_X:   return BYP_X;
            STG_M:   return BYP_M;
            STG_X2:  return BYP_X2;
            STG_X3:  return BYP_X3;
            default: return BYP_W;
        endcase
    endfunction

endpackage

// File: rtl/riscvlong_sb_operand_lookup.sv
// Priority match of one decode-stage source operand against the in-flight
// descriptors, plus the readiness check of the youngest matching producer.
module riscvlong_sb_operand_lookup
    import riscvlong_sb_pkg::*;
(
    input  logic                        dec_val,
    input  logic                        rs_en,
    input  logic [4:0]                  rs,
    input  logic [NUM_STG*DESC_W-1:0]   desc_vec,
    output logic [2:0]                  mux_sel,
    output logic                        not_ready
);

    sb_desc_t d;
    logic     found;

    // Youngest match wins; older matches are shadowed by the found flag
    always_comb begin
        mux_sel   = BYP_RF;
        not_ready = 1'b0;
        found     = 1'b0;
        d         = '0;
        for (int unsigned s = 0; s < NUM_STG; s++) begin
            d = desc_vec[s*DESC_W +: DESC_W];
            if (!found && dec_val && rs_en && (rs != 5'd0) && d.val && (d.rd == rs)) begin
                found = 1'b1;
                if (unit_ready(s, d.unit)) begin
                    mux_sel = stage_byp(s);
                end else begin
                    not_ready = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/riscvlong_core_scoreboard.sv
// Register-dependency scoreboard and bypass controller for the X/M/X2/X3/W
// pipeline: tracks one destination descriptor per stage, produces the
// decode operand bypass selects and the RAW stall request.
module riscvlong_core_scoreboard
    import riscvlong_sb_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_val_Dhl,
    input  logic [4:0]       rs1_Dhl,
    input  logic [4:0]       rs2_Dhl,
    input  logic             rs1_en_Dhl,
    input  logic             rs2_en_Dhl,
    input  logic [4:0]       rd_Dhl,
    input  logic             rf_wen_Dhl,
    input  logic [1:0]       unit_Dhl,
    input  logic             issue_Dhl,
    input  logic             stall_Xhl,
    input  logic             stall_Mhl,
    input  logic             stall_X2hl,
    input  logic             stall_X3hl,
    input  logic             stall_Whl,
    output logic [2:0]       rs1_mux_sel_Dhl,
    output logic [2:0]       rs2_mux_sel_Dhl,
    output logic             stall_raw_Dhl,
    output logic [31:0]      pend_vec,
    output logic [CNT_W-1:0] raw_stall_cnt
);

    sb_desc_t                  desc_q [NUM_STG];
    sb_desc_t                  desc_d [NUM_STG];
    logic [NUM_STG-1:0]        stall_vec;
    logic [NUM_STG*DESC_W-1:0] desc_vec;
    logic                      rs1_not_ready;
    logic                      rs2_not_ready;
    logic [CNT_W-1:0]          cnt_q;

    assign stall_vec = {stall_Whl, stall_X3hl, stall_X2hl, stall_Mhl, stall_Xhl};

    // Descriptor advance: hold on own stall, bubble behind a stalled predecessor
    always_comb begin
        for (int unsigned s = 0; s < NUM_STG; s++) begin
            desc_d[s] = desc_q[s];
        end
        if (!stall_vec[STG_X]) begin
            desc_d[STG_X].val  = issue_Dhl && rf_wen_Dhl && (rd_Dhl != 5'd0);
            desc_d[STG_X].rd   = rd_Dhl;
            desc_d[STG_X].unit = unit_Dhl;
        end
        for (int unsigned s = 1; s < NUM_STG; s++) begin
            if (!stall_vec[s]) begin
                desc_d[s] = stall_vec[s-1] ? '0 : desc_q[s-1];
            end
        end
    end

    // Descriptor registers; reset flushes every stage at once
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NUM_STG; s++) begin
            if (reset) begin
                desc_q[s] <= '0;
            end else begin
                desc_q[s] <= desc_d[s];
            end
        end
    end

    // Flatten descriptors for the operand lookups and build the pending vector
    always_comb begin
        desc_vec = '0;
        pend_vec = '0;
        for (int unsigned s = 0; s < NUM_STG; s++) begin
            desc_vec[s*DESC_W +: DESC_W] = desc_q[s];
            if (desc_q[s].val) begin
                pend_vec[desc_q[s].rd] = 1'b1;
            end
        end
    end

    riscvlong_sb_operand_lookup u_rs1_lookup (
        .dec_val   (dec_val_Dhl),
        .rs_en     (rs1_en_Dhl),
        .rs        (rs1_Dhl),
        .desc_vec  (desc_vec),
        .mux_sel   (rs1_mux_sel_Dhl),
        .not_ready (rs1_not_ready)
    );

    riscvlong_sb_operand_lookup u_rs2_lookup (
        .dec_val   (dec_val_Dhl),
        .rs_en     (rs2_en_Dhl),
        .rs        (rs2_Dhl),
        .desc_vec  (desc_vec),
        .mux_sel   (rs2_mux_sel_Dhl),
        .not_ready (rs2_not_ready)
    );

    assign stall_raw_Dhl = dec_val_Dhl && (rs1_not_ready || rs2_not_ready);

    // Saturating count of decode cycles lost to RAW hazards
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (dec_val_Dhl && stall_raw_Dhl && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign raw_stall_cnt = cnt_q;

endmodule

// File: doc/riscvlong_core_scoreboard.md
# riscvlong_core_scoreboard

Register-dependency scoreboard and bypass controller for the long (X/M/X2/X3/W) RISC-V pipeline. It tracks one destination descriptor per in-flight stage. From those descriptors it generates the decode-stage operand bypass selects (`rs1_mux_sel_Dhl`, `rs2_mux_sel_Dhl`) and a RAW stall request for results not yet producible. It sits beside the core control unit, which combines `stall_raw_Dhl` with its other stall sources and feeds the final per-stage stalls back.

## Interface
Parameters:
- `CNT_W`, default 32: width of the RAW-stall performance counter.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `dec_val_Dhl`  in  1  valid instruction in D
- `rs1_Dhl`, `rs2_Dhl`  in  5 each  source register addresses
- `rs1_en_Dhl`, `rs2_en_Dhl`  in  1 each  source is actually read
- `rd_Dhl`  in  5  destination register
- `rf_wen_Dhl`  in  1  instruction writes `rd`
- `unit_Dhl`  in  2  result producer: 0 ALU, 1 LOAD, 2 MULDIV (3 reserved, treated as MULDIV)
- `issue_Dhl`  in  1  D instruction moves to X this cycle
- `stall_Xhl`, `stall_Mhl`, `stall_X2hl`, `stall_X3hl`, `stall_Whl`  in  1 each  final per-stage stalls from control
- `rs1_mux_sel_Dhl`, `rs2_mux_sel_Dhl`  out  3 each  bypass select: 0 RF, 1 X, 2 M, 3 X2, 4 X3, 5 W
- `stall_raw_Dhl`  out  1  RAW hazard; D must not issue
- `pend_vec`  out  32  bit r set if any valid stage descriptor targets r
- `raw_stall_cnt`  out  CNT_W  cycles with `dec_val_Dhl && stall_raw_Dhl`

## Operation
- Five descriptor registers, one each for S ∈ {X, M, X2, X3, W}: `{val, rd[4:0], unit[1:0]}`.
- X load value: `val = issue_Dhl && rf_wen_Dhl && rd_Dhl != 0`.
- Each stage loads from its predecessor when its own stall is 0.
- If the predecessor's stall is 1 and its own stall is 0, the stage loads a bubble (`val = 0`).
- If its own stall is 1, the stage holds.
- A descriptor leaving W is discarded. The register file holds the value from the next cycle on.
- Operand lookup, done per operand independently:
  - A stage matches when `dec_val && rs_en && rs != 0 && S.val && S.rd == rs`.
  - The youngest matching stage wins, in priority order X, M, X2, X3, W.
  - Older matches are ignored.
- Readiness of the winning stage, by producer:
  - ALU is ready in every stage.
  - LOAD is not ready in X and ready from M onward.
  - MULDIV is not ready in X, M, X2 or X3, and is ready only in W.
- Winner ready: select = stage code (1–5).
- Winner not ready: select = 0 and `stall_raw_Dhl` is asserted.
- No match: select = 0.
- `stall_raw_Dhl` = OR of both operands' not-ready conditions. It is 0 when `dec_val_Dhl` is 0.
- `raw_stall_cnt` increments when `dec_val_Dhl && stall_raw_Dhl`. It saturates at all-ones.

## Timing
- Reset state: all `val` = 0, both selects 0, `stall_raw_Dhl` 0, `pend_vec` 0, `raw_stall_cnt` 0.
- Reset mid-operation flushes all descriptors in one cycle.
- Selects, `stall_raw_Dhl` and `pend_vec` are combinational from the descriptor registers and the D-stage inputs only.
- No combinational path exists from `issue_Dhl` or any `stall_*` input to any output, so control may derive `issue_Dhl` from `stall_raw_Dhl` without forming a loop.
- Zero-latency bypass: an ALU result issued at cycle t is selectable at t+1 with select 1.
- Load-use costs 1 stall cycle.
- A MULDIV consumer directly behind its producer stalls 4 cycles.
- Simultaneous issue and W retirement of the same `rd` is legal: the new X descriptor takes priority.
- Stalls are monotone: stall_S implies the stall of every earlier stage. This is guaranteed by control and not checked.

## Structure
- Shared package `riscvlong_sb_pkg`:
  - `UNIT_ALU`, `UNIT_LOAD`, `UNIT_MULDIV`
  - `BYP_RF`, `BYP_X`, `BYP_M`, `BYP_X2`, `BYP_X3`, `BYP_W`
  - stage-index constants
  - descriptor typedef
- Sub-module `riscvlong_sb_operand_lookup`:
  - Combinational priority match plus readiness check for one operand.
  - Instantiated twice, once for rs1 and once for rs2.

## Test plan
- Reset held 2 cycles, then released with no issue → all outputs 0 and `pend_vec` = 0.
- `add x5` issued at t, then `dec` reading rs1 = x5 each cycle with D stalled externally → selects 1, 2, 3, 4, 5 at t+1..t+5, then 0; stall never asserted.
- `lw x6` issued at t, consumer reading rs2 = x6 at t+1 → `stall_raw` = 1 and count = 1; at t+2 select = 2 and stall = 0.
- `mul x7` issued at t, consumer at t+1 → stall for t+1..t+4; at t+5 select = 5; `raw_stall_cnt` = 4.
- Priority and readiness:
  - `add x8` in W with `add x8` in M → select 2.
  - `mul x8` in M with `add x8` in X → select 1, no stall.
  - `rd` = x0 → never pending and never bypassed.
- `stall_Xhl` = `stall_Mhl` = 1 for one cycle with a valid descriptor in M → M holds, X2 receives a bubble, X holds.
